simon_seq_gen: RTL
==================

Name: simon_seq_gen

Overview:
Consumer stage for the 32-bit pseudo-random word produced by the free-running LFSR in io_devices.
- Turns that word into a growing Simon-style colour sequence and stores it in an internal register file.
- Plays the sequence back as timed LED-on/LED-off pulses.
- Exposes a random-access read port so the input checker can compare player presses against stored steps.

Parameters:
MAX_LEN, 32, maximum sequence length (steps stored)
ON_CYCLES, 25000000, clk cycles each colour is lit during playback (>=1)
OFF_CYCLES, 12500000, clk cycles of dark gap after each colour (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
random_num  in  32  current LFSR word, sampled on add_step
new_game  in  1  pulse: clear sequence, abort any playback
add_step  in  1  pulse: append one random colour
play  in  1  pulse: start playback of the whole sequence
query_idx  in  clog2(MAX_LEN)  step index for checker read
query_color  out  2  colour at query_idx (combinational read)
color_out  out  2  colour being played
led_valid  out  1  high while color_out must be lit
busy  out  1  high in any state other than IDLE
play_done  out  1  one-cycle pulse when playback ends
seq_len  out  clog2(MAX_LEN+1)  number of stored steps
full  out  1  seq_len == MAX_LEN

Behaviour:
- Reset (async, active-high): state=IDLE; seq_len=0, color_out=0, led_valid=0, play_done=0, busy=0, timer=0, play index=0. Register file contents are don't-care after reset.
- Colour extraction: color = random_num[1:0] ^ random_num[9:8]. Encoding: 0 RED, 1 GREEN, 2 BLUE, 3 YELLOW.
- States: IDLE, PLAY_ON, PLAY_OFF, DONE.
- new_game has top priority in every state. Next edge: seq_len=0, state=IDLE, led_valid=0, play_done=0, timer and play index cleared.
- Command priority in IDLE (new_game absent): add_step beats play. A play arriving in the same cycle as add_step is dropped.
- add_step in IDLE, not full: mem[seq_len] <= color and seq_len <= seq_len+1 on the same edge. Visible on query_color the next cycle (1-cycle latency).
- add_step when full: ignored, nothing changes.
- add_step in any state other than IDLE: ignored.
- play in IDLE with seq_len==0: go to DONE. play_done is high for exactly one cycle, then IDLE. led_valid is never asserted.
- play in IDLE with seq_len>0: next edge enters PLAY_ON with idx=0, timer=0.
- PLAY_ON: color_out=mem[idx], led_valid=1 for exactly ON_CYCLES cycles, then PLAY_OFF with timer=0.
- PLAY_OFF: led_valid=0 and color_out holds its last value, for exactly OFF_CYCLES cycles.
  - If idx==seq_len-1: go to DONE.
  - Else: idx++ and return to PLAY_ON.
- DONE: play_done=1 for one cycle, then IDLE.
- play received while busy: ignored (no restart).
- Sequence length is latched at playback start; it cannot change mid-play because add_step is ignored.
- query_color = mem[query_idx] when query_idx < seq_len, else 0. Independent of state.
- Timer is 32-bit; no wrap is possible for legal parameter values.

Decomposition:
- Shared package simon_pkg:
  - 2-bit colour type and constants RED/GREEN/BLUE/YELLOW
  - state enum
  - colour-extract function (bit positions 1:0 and 9:8)
- Sub-module seq_regfile: MAX_LEN x 2 storage.
  - One synchronous write port (we, waddr, wdata).
  - Two asynchronous read ports: playback index and query index.
- Top level holds the FSM, timer and seq_len counter.

Test Plan:
1. Use ON_CYCLES=3, OFF_CYCLES=2. Reset mid-playback (assert during PLAY_ON) -> same cycle: led_valid=0, busy=0, seq_len=0.
2. random_num=32'h00000102, add_step -> next cycle seq_len=1, query_idx=0 gives query_color=3. Add 32'h00000001 -> seq_len=2, query_color[1]=1.
3. With sequence {3,1}, pulse play -> led_valid high 3 cycles with color_out=3, low 2, high 3 with color_out=1, low 2. Then play_done one cycle, busy low. Total 11 cycles after the play edge.
4. play with seq_len=0 -> play_done pulses within 2 cycles, led_valid never high.
5. Fill to MAX_LEN=32, then add_step -> full=1, seq_len stays 32, stored entries unchanged. Simultaneous add_step+play in IDLE at seq_len=5 -> seq_len=6, no playback starts.
6. new_game during PLAY_OFF of step 1 -> next cycle state IDLE, seq_len=0, no play_done. play/add_step pulses during playback are ignored.

Source files
------------

// File: rtl/simon_pkg.sv
// +----------------------------------------------------------------------------+
// | simon_pkg: colour encoding, FSM state encoding and colour extraction.       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package simon_pkg;

  typedef logic [1:0] color_t;

  localparam color_t RED    = 2'd0;
  localparam color_t GREEN  = 2'd1;
  localparam color_t BLUE   = 2'd2;
  localparam color_t YELLOW = 2'd3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PLAY_ON  = 2'd1;
  localparam logic [1:0] S_PLAY_OFF = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  // Folding two byte lanes together spreads the LFSR entropy over the colour.
  function automatic color_t extract_color(input logic [31:0] word);
    return word[1:0] ^ word[9:8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_regfile.sv
// +----------------------------------------------------------------------------+
// | seq_regfile: MAX_LEN x 2-bit colour store, one sync write, two async reads.|
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_regfile
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_t        wdata,
  input  logic [AW-1:0] raddr_a,
  output color_t        rdata_a,
  input  logic [AW-1:0] raddr_b,
  output color_t        rdata_b
);

  color_t r_mem [MAX_LEN];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata_a = r_mem[raddr_a];
  assign rdata_b = r_mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/simon_seq_gen.sv
// +----------------------------------------------------------------------------+
// | simon_seq_gen: builds a random colour sequence and plays it back on LEDs.  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module simon_seq_gen
  import simon_pkg::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  localparam int IDX_W     = $clog2(MAX_LEN),
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      random_num,
  input  logic             new_game,
  input  logic             add_step,
  input  logic             play,
  input  logic [IDX_W-1:0] query_idx,
  output logic [1:0]       query_color,
  output logic [1:0]       color_out,
  output logic             led_valid,
  output logic             busy,
  output logic             play_done,
  output logic [LEN_W-1:0] seq_len,
  output logic             full
);

  localparam logic [31:0] c_ON_LAST  = 32'(ON_CYCLES - 1);
  localparam logic [31:0] c_OFF_LAST = 32'(OFF_CYCLES - 1);

  state_t           r_state;
  logic [31:0]      r_timer;
  logic [IDX_W-1:0] r_idx;
  logic [LEN_W-1:0] r_seq_len;
  color_t           r_last;

  color_t w_play_color;
  color_t w_query_rd;
  logic   w_full;
  logic   w_we;
  logic   w_on_last;
  logic   w_off_last;
  logic   w_last_step;

  assign w_full      = (r_seq_len == LEN_W'(MAX_LEN));
  assign w_we        = (r_state == S_IDLE) && !new_game && add_step && !w_full;
  assign w_on_last   = (r_timer == c_ON_LAST);
  assign w_off_last  = (r_timer == c_OFF_LAST);
  assign w_last_step = (LEN_W'(r_idx) == (r_seq_len - LEN_W'(1)));

  seq_regfile #(
    .MAX_LEN (MAX_LEN),
    .AW      (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .we      (w_we),
    .waddr   (r_seq_len[IDX_W-1:0]),
    .wdata   (extract_color(random_num)),
    .raddr_a (r_idx),
    .rdata_a (w_play_color),
    .raddr_b (query_idx),
    .rdata_b (w_query_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= 32'd0;
      r_idx     <= '0;
      r_seq_len <= '0;
      r_last    <= RED;
    end else if (new_game) begin
      r_state   <= S_IDLE;
      r_timer   <= 32'd0;
      r_idx     <= '0;
      r_seq_len <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // add_step wins over play; a coincident play is simply dropped.
          if (add_step) begin
            if (!w_full) begin
              r_seq_len <= r_seq_len + LEN_W'(1);
            end
          end else if (play) begin
            r_idx   <= '0;
            r_timer <= 32'd0;
            r_state <= (r_seq_len == '0) ? S_DONE : S_PLAY_ON;
          end
        end
        S_PLAY_ON: begin
          r_last <= w_play_color;
          if (w_on_last) begin
            r_timer <= 32'd0;
            r_state <= S_PLAY_OFF;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_PLAY_OFF: begin
          if (w_off_last) begin
            r_timer <= 32'd0;
            if (w_last_step) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_PLAY_ON;
            end
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The lit colour is read live; r_last keeps it steady through the dark gap.
  assign color_out   = (r_state == S_PLAY_ON) ? w_play_color : r_last;
  assign led_valid   = (r_state == S_PLAY_ON);
  assign busy        = (r_state != S_IDLE);
  assign play_done   = (r_state == S_DONE);
  assign seq_len     = r_seq_len;
  assign full        = w_full;
  assign query_color = (LEN_W'(query_idx) < r_seq_len) ? w_query_rd : RED;

endmodule

`default_nettype wire
